// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types, reset PC default and RV32 opcode constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous buffer of fetched {pc, instr} entries; flush beats push and pop
module fetch_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  // The fetch credit rule makes this unreachable; firing means the credit logic is broken
  assert property (@(posedge clk) disable iff (rst) !(push && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited word fetches and buffers instructions for decode
module fetch_unit import riscv_pkg::*; #(
  parameter int ADDRESS_WIDTH = XLEN,
  parameter int DATA_WIDTH = XLEN,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [ADDRESS_WIDTH-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count;
  logic fire, keep, pop, unused_bits;
  fetch_entry_t din, head;
  assign target = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
  assign unused_bits = ^redirect_target[1:0];
  // Buffered plus in-flight entries never exceed the FIFO, so every response has a slot
  assign imem_req_valid = !rst && !redirect &&
                          ({1'b0, fifo_count} + {1'b0, outstanding} < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign fire = imem_req_valid && imem_req_ready;
  assign keep = imem_rsp_valid && !redirect && drop_cnt == '0;
  assign instr_valid = fifo_count != '0;
  assign pop = instr_valid && instr_ready;
  assign din = '{pc: rsp_pc, instr: imem_rsp_data};
  assign instr = head.instr;
  assign instr_pc = head.pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        fetch_pc <= target;
        rsp_pc <= target;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
        if (keep) rsp_pc <= rsp_pc + ADDRESS_WIDTH'(4);
        else if (imem_rsp_valid) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(keep),
    .pop(pop),
    .flush(redirect),
    .din(din),
    .head(head),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a latency-configurable in-order instruction memory model
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  logic clk = 0, rst = 0;
  logic imem_req_valid, imem_req_ready = 1, imem_rsp_valid = 0;
  logic redirect = 0, instr_valid, instr_ready = 0;
  logic [31:0] imem_addr, imem_rsp_data = 0, redirect_target = 0, instr, instr_pc;
  int n_cmp = 0, n_err = 0, cyc = 0, lat = 1, fires = 0;
  typedef struct { logic [31:0] a; int due; } req_t;
  req_t mq[$];
  logic [31:0] exp_q[$];
  logic stall_q = 0;
  logic [31:0] stall_addr = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // memory: instruction word at address a is ~a, returned lat cycles after acceptance
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      mq.delete();
      fires = 0;
      imem_rsp_valid = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_addr, cyc + lat});
        fires++;
      end
      if (mq.size() > 0 && mq[0].due == cyc) begin
        imem_rsp_valid = 1;
        imem_rsp_data = ~mq[0].a;
        void'(mq.pop_front());
      end else imem_rsp_valid = 0;
    end
  end

  // scoreboard on delivered instructions plus request-hold monitor
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (rst) stall_q = 0;
    else begin
      if (stall_q && !redirect) begin
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== stall_addr) begin
          n_err++;
          $display("FAIL req_hold: valid=%b addr=%h required valid=1 addr=%h", imem_req_valid, imem_addr, stall_addr);
        end
      end
      stall_q = imem_req_valid && !imem_req_ready;
      stall_addr = imem_addr;
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_instr: pc=%h instr=%h required none", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e || instr !== ~e) begin
            n_err++;
            $display("FAIL instr: pc=%h instr=%h required pc=%h instr=%h", instr_pc, instr, e, ~e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    exp_q.delete();
    redirect = 0;
    instr_ready = 0;
    imem_req_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic drain(input int budget, input bit rnd, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        instr_ready = 0;
        imem_req_ready = 1;
        ok = 1;
        break;
      end
      instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) imem_req_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    #3 rst = 1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 0 || instr_valid !== 0 || instr !== 0 || instr_pc !== 0 || imem_addr !== RPC) begin
      n_err++;
      $display("FAIL reset: req_valid=%b instr_valid=%b instr=%h instr_pc=%h addr=%h required 0 0 0 0 %h",
               imem_req_valid, instr_valid, instr, instr_pc, imem_addr, RPC);
    end
    do_reset();
  endtask

  task automatic test_stream();
    lat = 1;
    do_reset();
    instr_ready = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(RPC + 32'(4 * i));
    #1;
    n_cmp++;
    if (imem_req_valid !== 1 || imem_addr !== RPC || instr_valid !== 0) begin
      n_err++;
      $display("FAIL first_req: valid=%b addr=%h instr_valid=%b required 1 %h 0", imem_req_valid, imem_addr, instr_valid, RPC);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (instr_valid !== 0 || imem_addr !== RPC + 32'd4) begin
      n_err++;
      $display("FAIL second_req: instr_valid=%b addr=%h required 0 %h", instr_valid, imem_addr, RPC + 32'd4);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (instr_valid !== 1 || instr_pc !== RPC + 32'(4 * i)) begin
        n_err++;
        $display("FAIL stream[%0d]: valid=%b pc=%h required 1 %h", i, instr_valid, instr_pc, RPC + 32'(4 * i));
      end
    end
    @(negedge clk);
    instr_ready = 0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_left: %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(RPC + 32'(4 * i));
    repeat (8) @(negedge clk);
    #1;
    n_cmp++;
    if (fires != 4 || instr_valid !== 1 || imem_req_valid !== 0) begin
      n_err++;
      $display("FAIL fill: fires=%0d instr_valid=%b req_valid=%b required 4 1 0", fires, instr_valid, imem_req_valid);
    end
    @(negedge clk) instr_ready = 1;
    @(negedge clk) instr_ready = 0;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (fires != 5) begin
      n_err++;
      $display("FAIL one_credit: fires=%0d required 5", fires);
    end
    drain(40, 0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_drain: %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    lat = 3;
    do_reset();
    instr_ready = 1;
    repeat (3) @(negedge clk);
    redirect = 1;
    redirect_target = 32'h100;
    #1;
    n_cmp++;
    if (imem_req_valid !== 0 || fires != 3) begin
      n_err++;
      $display("FAIL redir_req: valid=%b fires=%0d required 0 3", imem_req_valid, fires);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    @(negedge clk) redirect = 0;
    drain(40, 0, ok);
    n_cmp++;
    if (!ok || dut.drop_cnt !== 0) begin
      n_err++;
      $display("FAIL redir_drain: ok=%b drop_cnt=%0d required 1 0", ok, dut.drop_cnt);
    end
  endtask

  task automatic test_redirect_with_rsp();
    bit ok;
    lat = 1;
    do_reset();
    instr_ready = 1;
    @(negedge clk);
    redirect = 1;
    redirect_target = 32'h203;
    #1;
    n_cmp++;
    if (imem_req_valid !== 0) begin
      n_err++;
      $display("FAIL rsp_redir_req: valid=%b required 0", imem_req_valid);
    end
    @(negedge clk) redirect = 0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1 || imem_addr !== 32'h200 || instr_valid !== 0) begin
      n_err++;
      $display("FAIL aligned_target: valid=%b addr=%h instr_valid=%b required 1 00000200 0", imem_req_valid, imem_addr, instr_valid);
    end
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    drain(40, 0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL rsp_redir_drain: %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    lat = 2;
    do_reset();
    instr_ready = 1;
    @(negedge clk);
    redirect = 1;
    redirect_target = 32'h40;
    @(negedge clk);
    redirect_target = 32'h80;
    @(negedge clk);
    redirect = 0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1 || imem_addr !== 32'h80 || dut.drop_cnt !== 0) begin
      n_err++;
      $display("FAIL b2b_target: valid=%b addr=%h drop_cnt=%0d required 1 00000080 0", imem_req_valid, imem_addr, dut.drop_cnt);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h80 + 32'(4 * i));
    drain(40, 0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_drain: %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_random_stall();
    bit ok;
    lat = 2;
    do_reset();
    for (int i = 0; i < 12; i++) exp_q.push_back(RPC + 32'(4 * i));
    drain(400, 1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL rand_drain: %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    lat = 1;
    do_reset();
    instr_ready = 1;
    for (int i = 0; i < 20; i++) exp_q.push_back(RPC + 32'(4 * i));
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 0 || instr_valid !== 0 || imem_addr !== RPC || dut.outstanding !== 0) begin
      n_err++;
      $display("FAIL mid_reset: req_valid=%b instr_valid=%b addr=%h outstanding=%0d required 0 0 %h 0",
               imem_req_valid, instr_valid, imem_addr, dut.outstanding, RPC);
    end
    do_reset();
    instr_ready = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(RPC + 32'(4 * i));
    drain(40, 0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL restart_drain: %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
